uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, meaning TX FIFO entries (power of two, 2..256).
REQ-002 The block SHALL have parameter DIV_WIDTH, default 16, meaning width of the baud divisor register.
REQ-003 The block SHALL have parameter DIV_RESET, default 868, meaning the divisor value after reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 The block SHALL have port en, input, 1, bus select for this peripheral.
REQ-007 The block SHALL have port write_enable, input, 3, write strobe; bit 2 qualifies register writes.
REQ-008 The block SHALL have port addr, input, 24, byte address; only addr[3:0] is decoded.
REQ-009 The block SHALL have port data_in, input, 32, write data.
REQ-010 The block SHALL have port data_out, output, 32, read data, combinational from addr[3:0].
REQ-011 The block SHALL have port uart_txd, output, 1, serial line, idle high.
REQ-012 The block SHALL have port uart_tx_busy, output, 1, high while the FIFO is non-empty or a frame is in flight.
REQ-013 The block SHALL have port irq, output, 1, high when the TX-empty interrupt is enabled and FIFO empty and shifter idle.

Function
REQ-014 Write = en & write_enable[2]; addr 0x2 pushes data_in[7:0], addr 0x4 writes CTRL, addr 0x8 writes DIV[DIV_WIDTH-1:0]; other addresses are ignored.
REQ-015 CTRL: bit0 parity enable, bit1 odd parity, bit2 two stop bits, bit3 7-bit data, bit4 irq enable.
REQ-016 Reads: 0x4 returns CTRL, 0x8 returns DIV, 0xC returns STATUS {level[8:0] at [16:8], overflow[3], busy[2], full[1], empty[0]}; other addresses return 0.
REQ-017 A push to a full FIFO SHALL be dropped, set sticky overflow, and leave FIFO contents unchanged.
REQ-018 A write to 0xC with data_in[3]=1 SHALL clear overflow; if an overflow happens in the same cycle, overflow stays set.
REQ-019 FIFO SHALL use wrap-around pointers with one extra bit; full = FIFO_DEPTH entries; push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-020 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP; encoding is shared.
REQ-021 In IDLE, when the FIFO is non-empty, the block SHALL pop one byte into the shifter and enter START on the next clk, latching CTRL and DIV for the whole frame.
REQ-022 Each bit SHALL hold uart_txd for exactly DIV+1 clk cycles; DIV=0 gives one cycle per bit.
REQ-023 Bits SHALL be sent LSB first: START(0), 8 or 7 data bits, optional parity (even: XOR of data bits; odd: inverted), then 1 or 2 STOP(1) bits.
REQ-024 After the last stop bit, the block SHALL return to IDLE and may start the next frame on the following cycle, so back-to-back frames have no extra idle gap beyond one clk.
REQ-025 CTRL/DIV writes during a frame SHALL take effect from the next frame only.
REQ-026 uart_txd SHALL be 1 in IDLE and STOP, and SHALL be registered (glitch-free).

Reset
REQ-027 While rst_n=0 at a clk edge: state IDLE, FIFO empty, overflow 0, CTRL 0, DIV=DIV_RESET, uart_txd 1, uart_tx_busy 0, irq 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame, driving uart_txd high on the cycle after the reset edge and discarding queued data.

Structure
REQ-029 State encoding, register offsets and CTRL/STATUS bit positions SHALL live in a shared package uart_pkg.
REQ-030 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, level).

Verification
REQ-031 DIV=3, CTRL=0, push 0x55 -> txd: start 0, then 1,0,1,0,1,0,1,0, stop 1; each bit 4 clk; busy drops after 40 clk.
REQ-032 DIV=0, CTRL=0x5 (parity even, 2 stop), push 0x07 -> 1+8+1+2=12 bit cycles; parity bit 1.
REQ-033 DIV=0, CTRL=0x0B (7-bit, odd parity), push 0x80 -> 7 data bits all 0, parity 1, 10 bit cycles total.
REQ-034 Push FIFO_DEPTH+2 bytes while DIV=100 -> full=1, overflow=1, first 17 bytes (16 queued + 1 in shifter) sent in order; clear via 0xC write -> overflow 0.
REQ-035 Mid-frame rst_n low for 1 cycle -> txd 1 next cycle, STATUS reads empty=1, busy=0, DIV=DIV_RESET.
REQ-036 CTRL irq enable, push 2 bytes, DIV=1 -> irq low until second stop bit ends, then high; DIV write mid-frame changes only the second frame's bit timing.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame states, register map,
// CTRL/STATUS bit positions and the frame parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Register offsets (addr[3:0])
  localparam logic [3:0] ADDR_TXDATA = 4'h2;
  localparam logic [3:0] ADDR_CTRL   = 4'h4;
  localparam logic [3:0] ADDR_DIV    = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  // CTRL bit positions
  localparam int unsigned CTRL_PAR_EN  = 0;
  localparam int unsigned CTRL_PAR_ODD = 1;
  localparam int unsigned CTRL_STOP2   = 2;
  localparam int unsigned CTRL_DATA7   = 3;
  localparam int unsigned CTRL_IRQ_EN  = 4;
  localparam int unsigned CTRL_W       = 5;

  // STATUS bit positions
  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_BUSY      = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_LEVEL_LSB = 8;

  // Parity over the transmitted data bits; odd parity is the inverted XOR.
  function automatic logic frame_parity(input logic [7:0] b, input logic data7,
                                        input logic odd);
    logic p;
    p = data7 ? ^b[6:0] : ^b;
    return p ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-around pointers (one extra bit distinguishes
// full from empty). A push on a full FIFO is accepted only when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign level     = r_wr_ptr - r_rd_ptr;
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO, CTRL/DIV/STATUS registers and a
// TX-empty interrupt. Frame format and bit period are latched when a byte
// leaves the FIFO, so register writes only affect later frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  write_enable,
  input  logic [23:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_txd,
  output logic        uart_tx_busy,
  output logic        irq
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]           w_a;
  logic                 w_wr;
  logic                 w_push;
  logic                 w_wr_ctrl;
  logic                 w_wr_div;
  logic                 w_wr_stat;
  logic                 w_pop;
  logic                 w_drop;
  logic [7:0]           w_fifo_dout;
  logic                 w_full;
  logic                 w_empty;
  logic [LVL_W-1:0]     w_level;
  logic [2:0]           w_last_bit;
  logic                 w_unused;

  logic [CTRL_W-1:0]    r_ctrl;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_ovf;
  state_t               r_state;
  logic                 r_txd;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_fdiv;
  logic [3:0]           r_fctrl;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit;
  logic                 r_par;
  logic                 r_stop2nd;

  assign w_a       = addr[3:0];
  assign w_wr      = en && write_enable[2];
  assign w_push    = w_wr && (w_a == ADDR_TXDATA);
  assign w_wr_ctrl = w_wr && (w_a == ADDR_CTRL);
  assign w_wr_div  = w_wr && (w_a == ADDR_DIV);
  assign w_wr_stat = w_wr && (w_a == ADDR_STATUS);
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_unused  = &{1'b0, addr[23:4], write_enable[1:0], data_in};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (data_in[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // Configuration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_div  <= DIV_WIDTH'(DIV_RESET);
    end else begin
      if (w_wr_ctrl) r_ctrl <= data_in[CTRL_W-1:0];
      if (w_wr_div)  r_div  <= data_in[DIV_WIDTH-1:0];
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n)                                r_ovf <= 1'b0;
    else if (w_drop)                           r_ovf <= 1'b1;
    else if (w_wr_stat && data_in[STAT_OVF])   r_ovf <= 1'b0;
  end

  assign w_last_bit = r_fctrl[CTRL_DATA7] ? 3'd6 : 3'd7;

  // Frame sequencer: each bit is held for r_fdiv+1 cycles, txd is registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_txd     <= 1'b1;
      r_cnt     <= '0;
      r_fdiv    <= '0;
      r_fctrl   <= '0;
      r_shift   <= '0;
      r_bit     <= '0;
      r_par     <= 1'b0;
      r_stop2nd <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_txd <= 1'b1;
      if (!w_empty) begin
        r_state <= ST_START;
        r_txd   <= 1'b0;
        r_shift <= w_fifo_dout;
        r_par   <= frame_parity(w_fifo_dout, r_ctrl[CTRL_DATA7], r_ctrl[CTRL_PAR_ODD]);
        r_fctrl <= r_ctrl[3:0];
        r_fdiv  <= r_div;
        r_cnt   <= '0;
      end
    end else if (r_cnt != r_fdiv) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
      case (r_state)
        ST_START: begin
          r_state <= ST_DATA;
          r_txd   <= r_shift[0];
          r_shift <= {1'b0, r_shift[7:1]};
          r_bit   <= '0;
        end
        ST_DATA: begin
          if (r_bit == w_last_bit) begin
            r_stop2nd <= 1'b0;
            if (r_fctrl[CTRL_PAR_EN]) begin
              r_state <= ST_PARITY;
              r_txd   <= r_par;
            end else begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end
          end else begin
            r_bit   <= r_bit + 1'b1;
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
        ST_PARITY: begin
          r_state <= ST_STOP;
          r_txd   <= 1'b1;
        end
        ST_STOP: begin
          r_txd <= 1'b1;
          if (r_fctrl[CTRL_STOP2] && !r_stop2nd) r_stop2nd <= 1'b1;
          else                                   r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign uart_txd     = r_txd;
  assign uart_tx_busy = !w_empty || (r_state != ST_IDLE);
  assign irq          = r_ctrl[CTRL_IRQ_EN] && w_empty && (r_state == ST_IDLE);

  // Register read mux
  always_comb begin
    data_out = '0;
    case (w_a)
      ADDR_CTRL:   data_out[CTRL_W-1:0]    = r_ctrl;
      ADDR_DIV:    data_out[DIV_WIDTH-1:0] = r_div;
      ADDR_STATUS: begin
        data_out[STAT_LEVEL_LSB+8:STAT_LEVEL_LSB] = 9'(w_level);
        data_out[STAT_OVF]   = r_ovf;
        data_out[STAT_BUSY]  = uart_tx_busy;
        data_out[STAT_FULL]  = w_full;
        data_out[STAT_EMPTY] = w_empty;
      end
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DIVW  = 16;
  localparam int unsigned DIVR  = 868;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  write_enable = 3'b000;
  logic [23:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        uart_txd;
  logic        uart_tx_busy;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  bit   rec = 1'b0;
  logic tr_tx[$];
  logic tr_busy[$];
  logic tr_irq[$];
  logic exp_tx[$];
  logic exp_busy[$];
  logic exp_irq[$];

  uart_tx_fifo #(
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DIVW),
    .DIV_RESET  (DIVR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .write_enable (write_enable),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Line recorder: one sample per clock, taken mid-cycle
  always @(negedge clk) begin
    if (rec) begin
      tr_tx.push_back(uart_txd);
      tr_busy.push_back(uart_tx_busy);
      tr_irq.push_back(irq);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
    en = 1'b1;
    write_enable = 3'b100;
    addr = a;
    data_in = d;
    tick();
    en = 1'b0;
    write_enable = 3'b000;
    data_in = '0;
  endtask

  task automatic bus_read(input logic [23:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = data_out;
  endtask

  // Reference line behaviour: two idle samples around the first push, each
  // frame bit repeated div+1 times, one idle cycle between queued frames,
  // then an idle tail. irq is the enable bit while nothing is pending.
  function automatic void build_expect(input logic [7:0] bq[$], input logic [4:0] c,
                                       input int unsigned d0, input int unsigned dn,
                                       input int unsigned tail);
    exp_tx.delete();
    exp_busy.delete();
    exp_irq.delete();
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b1);
    for (int k = 0; k < bq.size(); k++) begin
      int unsigned d;
      int unsigned nb;
      logic        p;
      logic        bits[$];
      d  = (k == 0) ? d0 : dn;
      nb = c[3] ? 7 : 8;
      p  = 1'b0;
      bits.push_back(1'b0);
      for (int unsigned i = 0; i < nb; i++) begin
        bits.push_back(bq[k][i]);
        p = p ^ bq[k][i];
      end
      if (c[0]) bits.push_back(c[1] ? ~p : p);
      bits.push_back(1'b1);
      if (c[2]) bits.push_back(1'b1);
      foreach (bits[j]) begin
        for (int unsigned r = 0; r <= d; r++) begin
          exp_tx.push_back(bits[j]);
          exp_busy.push_back(1'b1);
        end
      end
      if (k != bq.size() - 1) begin
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b1);
      end
    end
    for (int unsigned t = 0; t < tail; t++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
    foreach (exp_busy[i]) exp_irq.push_back(c[4] & ~exp_busy[i]);
  endfunction

  function automatic int count_mis(input logic a[$], input logic e[$], output int first);
    int n = 0;
    first = -1;
    for (int i = 0; i < e.size(); i++) begin
      if (i >= a.size() || a[i] !== e[i]) begin
        n++;
        if (first < 0) first = i;
      end
    end
    return n;
  endfunction

  // Push bytes (optionally followed by a DIV write) while recording the line
  task automatic play(input logic [7:0] bq[$], input bit mid, input logic [31:0] nd);
    int guard;
    tr_tx.delete();
    tr_busy.delete();
    tr_irq.delete();
    rec = 1'b1;
    foreach (bq[i]) bus_write(24'h2, {24'd0, bq[i]});
    if (mid) bus_write(24'h8, nd);
    guard = 0;
    while (tr_tx.size() < exp_tx.size() && guard < exp_tx.size() + 16) begin
      tick();
      guard++;
    end
    rec = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: txd=%b busy=%b irq=%b, required 1 0 0", uart_txd, uart_tx_busy, irq);
    end
    rst_n = 1'b1;
    tick();
    bus_read(24'hC, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL reset_status: got %08h, required %08h", d, 32'h1);
    end
    bus_read(24'h4, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %08h, required 0", d);
    end
    bus_read(24'h8, d);
    tests_run++;
    if (d !== DIVR) begin
      tests_failed++;
      $display("FAIL reset_div: got %0d, required %0d", d, DIVR);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [23:0] unm[4];
    unm = '{24'h0, 24'h2, 24'h6, 24'hE};
    bus_write(24'h4, 32'h1F);
    bus_read(24'h4, d);
    tests_run++;
    if (d !== 32'h1F) begin
      tests_failed++;
      $display("FAIL ctrl_rw: got %08h, required 0000001f", d);
    end
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_idle_enabled: got %b, required 1", irq);
    end
    bus_write(24'h4, 32'hFFFF_FFEA);
    bus_read(24'h4, d);
    tests_run++;
    if (d !== 32'h0A || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL ctrl_width: got ctrl=%08h irq=%b, required 0000000a 0", d, irq);
    end
    bus_write(24'h8, 32'h0001_2345);
    bus_read(24'h8, d);
    tests_run++;
    if (d !== 32'h2345) begin
      tests_failed++;
      $display("FAIL div_rw: got %08h, required 00002345", d);
    end
    en = 1'b0; write_enable = 3'b100; addr = 24'h8; data_in = 32'h55;
    tick();
    en = 1'b1; write_enable = 3'b011;
    tick();
    en = 1'b0; write_enable = 3'b000; data_in = '0;
    bus_read(24'h8, d);
    tests_run++;
    if (d !== 32'h2345) begin
      tests_failed++;
      $display("FAIL unqualified_write: got div %08h, required 00002345", d);
    end
    bus_write(24'h6, 32'hAA);
    bus_write(24'h10_0002 & 24'hFF_FFF0 | 24'h3, 32'hAB);
    bus_read(24'hC, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL unmapped_write: got status %08h, required 00000001", d);
    end
    bus_write(24'h4, 32'hFFFF_FFFF);
    foreach (unm[i]) begin
      bus_read(unm[i], d);
      tests_run++;
      if (d !== 32'h0) begin
        tests_failed++;
        $display("FAIL unmapped_read_%0h: got %08h, required 0", unm[i], d);
      end
    end
    bus_write(24'h4, 32'h0);
  endtask

  task automatic test_frames();
    logic [7:0]  bq[$];
    logic [4:0]  cfg_c[3];
    int unsigned cfg_d[3];
    logic [7:0]  cfg_b[3];
    int mis, first;
    cfg_c = '{5'h00, 5'h05, 5'h0B};
    cfg_d = '{3, 0, 0};
    cfg_b = '{8'h55, 8'h07, 8'h80};
    for (int t = 0; t < 3; t++) begin
      bus_write(24'h8, cfg_d[t]);
      bus_write(24'h4, {27'd0, cfg_c[t]});
      bq.delete();
      bq.push_back(cfg_b[t]);
      build_expect(bq, cfg_c[t], cfg_d[t], cfg_d[t], 3);
      play(bq, 1'b0, '0);
      mis = count_mis(tr_tx, exp_tx, first);
      tests_run++;
      if (mis != 0) begin
        tests_failed++;
        $display("FAIL frame%0d_txd: %0d bad samples (first %0d), required 0", t, mis, first);
      end
      mis = count_mis(tr_busy, exp_busy, first);
      tests_run++;
      if (mis != 0) begin
        tests_failed++;
        $display("FAIL frame%0d_busy: %0d bad samples (first %0d), required 0", t, mis, first);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0]  bq[$];
    logic [4:0]  c;
    int unsigned d;
    int mis, first;
    for (int it = 0; it < 8; it++) begin
      c = 5'($urandom);
      d = $urandom_range(0, 3);
      bus_write(24'h8, d);
      bus_write(24'h4, {27'd0, c});
      bq.delete();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) bq.push_back(8'($urandom));
      build_expect(bq, c, d, d, 3);
      play(bq, 1'b0, '0);
      mis = count_mis(tr_tx, exp_tx, first);
      tests_run++;
      if (mis != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_txd: c=%h d=%0d n=%0d, %0d bad samples (first %0d), required 0",
                 it, c, d, bq.size(), mis, first);
      end
      mis = count_mis(tr_busy, exp_busy, first);
      tests_run++;
      if (mis != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_busy: %0d bad samples (first %0d), required 0", it, mis, first);
      end
      mis = count_mis(tr_irq, exp_irq, first);
      tests_run++;
      if (mis != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_irq: %0d bad samples (first %0d), required 0", it, mis, first);
      end
    end
    bus_write(24'h4, 32'h0);
  endtask

  task automatic test_overflow();
    logic [7:0]  all[$];
    logic [7:0]  sent[$];
    logic [31:0] d;
    logic [31:0] want;
    int mis, first, guard;
    bus_write(24'h8, 32'd100);
    bus_write(24'h4, 32'h0);
    for (int k = 0; k < DEPTH + 2; k++) all.push_back(8'($urandom));
    for (int k = 0; k < DEPTH + 1; k++) sent.push_back(all[k]);
    build_expect(sent, 5'h00, 100, 100, 3);
    tr_tx.delete(); tr_busy.delete(); tr_irq.delete();
    rec = 1'b1;
    foreach (all[i]) bus_write(24'h2, {24'd0, all[i]});
    bus_read(24'hC, d);
    want = (DEPTH << 8) | 32'hE;
    tests_run++;
    if (d !== want) begin
      tests_failed++;
      $display("FAIL overflow_status: got %08h, required %08h", d, want);
    end
    bus_write(24'hC, 32'h8);
    bus_read(24'hC, d);
    want = (DEPTH << 8) | 32'h6;
    tests_run++;
    if (d !== want) begin
      tests_failed++;
      $display("FAIL overflow_clear: got %08h, required %08h", d, want);
    end
    guard = 0;
    while (tr_tx.size() < exp_tx.size() && guard < exp_tx.size() + 16) begin
      tick();
      guard++;
    end
    rec = 1'b0;
    mis = count_mis(tr_tx, exp_tx, first);
    tests_run++;
    if (mis != 0) begin
      tests_failed++;
      $display("FAIL overflow_order_txd: %0d bad samples (first %0d), required 0", mis, first);
    end
    bus_read(24'hC, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL overflow_drained: got %08h, required 00000001", d);
    end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] d;
    int bad;
    bus_write(24'h8, 32'd3);
    bus_write(24'h4, 32'h05);
    for (int k = 0; k < 3; k++) bus_write(24'h2, 32'h0F + k);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_line: txd=%b busy=%b, required 1 0", uart_txd, uart_tx_busy);
    end
    bus_read(24'hC, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL midreset_status: got %08h, required 00000001", d);
    end
    bus_read(24'h8, d);
    tests_run++;
    if (d !== DIVR) begin
      tests_failed++;
      $display("FAIL midreset_div: got %0d, required %0d", d, DIVR);
    end
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL midreset_discard: %0d active cycles after reset, required 0", bad);
    end
  endtask

  task automatic test_irq_div_change();
    logic [7:0] bq[$];
    int mis, first;
    bus_write(24'h8, 32'd1);
    bus_write(24'h4, 32'h10);
    bq.push_back(8'($urandom));
    bq.push_back(8'($urandom));
    build_expect(bq, 5'h10, 1, 3, 4);
    play(bq, 1'b1, 32'd3);
    mis = count_mis(tr_tx, exp_tx, first);
    tests_run++;
    if (mis != 0) begin
      tests_failed++;
      $display("FAIL divchange_txd: %0d bad samples (first %0d), required 0", mis, first);
    end
    mis = count_mis(tr_irq, exp_irq, first);
    tests_run++;
    if (mis != 0) begin
      tests_failed++;
      $display("FAIL irq_timing: %0d bad samples (first %0d), required 0", mis, first);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_frames();
    test_random_frames();
    test_irq_div_change();
    test_overflow();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
